// File: rtl/multicycle_alu.sv
// multicycle_alu: ALU with 1-cycle logic/arith ops and optional bit-serial MUL/MUH/DIV/MOD.
// Ports: Clock, Reset, In* request handshake, Out* result handshake; macro MULTICYCLE_ALU_MULDIV_EN.
module multicycle_alu #(
  parameter int DATA_WIDTH = 16,
  parameter int OP_WIDTH   = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [OP_WIDTH-1:0]   Operation,
  input  logic [DATA_WIDTH-1:0] InSrc,
  input  logic [DATA_WIDTH-1:0] InDest,
  input  logic [3:0]            InFlags,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [DATA_WIDTH-1:0] OutDest,
  output logic [3:0]            OutFlags,
  output logic                  DivByZero
);
  localparam int DW = DATA_WIDTH;

  localparam logic [OP_WIDTH-1:0] OP_MOVE = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_NAND = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_NOR  = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_ROL  = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_ROR  = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_ADC  = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_SUB  = OP_WIDTH'(6);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;

  assign InReady  = (state == IDLE);
  assign OutValid = (state == DONE);

  // single-cycle datapath; flags are {C, Z, N, V}
  logic [DW-1:0] sc_res;
  logic [DW:0]   sum;
  logic          sc_c, sc_v, sc_def;
  logic [3:0]    sc_flg;

  always_comb begin
    sc_res = '0;
    sum    = '0;
    sc_c   = InFlags[3];
    sc_v   = InFlags[0];
    sc_def = 1'b1;
    unique case (1'b1)
      (Operation == OP_MOVE): sc_res = InSrc;
      (Operation == OP_NAND): sc_res = ~(InDest & InSrc);
      (Operation == OP_NOR):  sc_res = ~(InDest | InSrc);
      (Operation == OP_ROL): begin
        sc_res = {InSrc[DW-2:0], InFlags[3]};
        sc_c   = InSrc[DW-1];
      end
      (Operation == OP_ROR): begin
        sc_res = {InFlags[3], InSrc[DW-1:1]};
        sc_c   = InSrc[0];
      end
      (Operation == OP_ADC): begin
        sum    = {1'b0, InDest} + {1'b0, InSrc}
               + (DW+1)'(InFlags[3]);
        sc_res = sum[DW-1:0];
        sc_c   = sum[DW];
        sc_v   = (InDest[DW-1] == InSrc[DW-1])
               && (sum[DW-1] != InDest[DW-1]);
      end
      (Operation == OP_SUB): begin
        sum    = {1'b0, InDest} - {1'b0, InSrc}
               - (DW+1)'(InFlags[3]);
        sc_res = sum[DW-1:0];
        sc_c   = sum[DW];
        sc_v   = (InDest[DW-1] != InSrc[DW-1])
               && (sum[DW-1] != InDest[DW-1]);
      end
      default: sc_def = 1'b0;
    endcase
    sc_flg = sc_def
      ? {sc_c, sc_res == '0, sc_res[DW-1], sc_v}
      : InFlags;
  end

`ifdef MULTICYCLE_ALU_MULDIV_EN
  localparam logic [OP_WIDTH-1:0] OP_MUL = OP_WIDTH'(7);
  localparam logic [OP_WIDTH-1:0] OP_DIV = OP_WIDTH'(9);
  localparam logic [OP_WIDTH-1:0] OP_MOD = OP_WIDTH'(10);
  localparam int CW = $clog2(DW);

  logic [CW-1:0]   cnt;
  logic [1:0]      sel;
  logic [DW-1:0]   hi, lo, opnd, hi_n, lo_n;
  logic [DW-1:0]   abs_s, abs_d, quo, rem, md_res;
  logic [DW:0]     rs;
  logic [2*DW-1:0] mag, prod;
  logic [3:0]      flg_q, md_flg;
  logic            sneg, dneg, dz, dvo, md_v, geq;
  logic            is_md, is_div;

  assign is_md  = (Operation >= OP_MUL) && (Operation <= OP_MOD);
  assign is_div = (Operation == OP_DIV) || (Operation == OP_MOD);
  assign abs_s  = InSrc[DW-1] ? -InSrc : InSrc;
  assign abs_d  = InDest[DW-1] ? -InDest : InDest;

  // sel: 0 MUL, 1 MUH, 2 DIV, 3 MOD. Both units work on magnitudes;
  // multiply shifts {hi,lo} right, divide is restoring with lo as quotient.
  always_comb begin
    geq = 1'b0;
    if (!sel[1]) begin
      rs   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
      hi_n = rs[DW:1];
      lo_n = {rs[0], lo[DW-1:1]};
    end else begin
      rs   = {hi, lo[DW-1]};
      geq  = rs >= {1'b0, opnd};
      hi_n = geq ? DW'(rs - {1'b0, opnd}) : rs[DW-1:0];
      lo_n = {lo[DW-2:0], geq};
    end
    mag  = {hi_n, lo_n};
    prod = sneg ? -mag : mag;
    quo  = dz ? '1 : (sneg ? -lo_n : lo_n);
    rem  = dneg ? -hi_n : hi_n;
    md_v = flg_q[0];
    case (sel)
      2'd0: begin
        md_res = prod[DW-1:0];
        md_v   = !((&prod[2*DW-1:DW-1]) || !(|prod[2*DW-1:DW-1]));
      end
      2'd1: md_res = prod[2*DW-1:DW];
      2'd2: begin
        md_res = quo;
        md_v   = dvo | flg_q[0];
      end
      default: md_res = rem;
    endcase
    md_flg = {flg_q[3], md_res == '0, md_res[DW-1], md_v};
  end
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      OutDest   <= '0;
      OutFlags  <= '0;
      DivByZero <= 1'b0;
`ifdef MULTICYCLE_ALU_MULDIV_EN
      cnt       <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: if (InValid) begin
`ifdef MULTICYCLE_ALU_MULDIV_EN
          if (is_md) begin
            state <= BUSY;
            cnt   <= '0;
            sel   <= 2'(Operation - OP_MUL);
            flg_q <= InFlags;
            hi    <= '0;
            lo    <= is_div ? abs_d : abs_s;
            opnd  <= is_div ? abs_s : abs_d;
            sneg  <= InDest[DW-1] ^ InSrc[DW-1];
            dneg  <= InDest[DW-1];
            dz    <= is_div && (InSrc == '0);
            dvo   <= (InDest == {1'b1, {(DW-1){1'b0}}}) && (&InSrc);
          end else
`endif
          begin
            state     <= DONE;
            OutDest   <= sc_res;
            OutFlags  <= sc_flg;
            DivByZero <= 1'b0;
          end
        end
        BUSY: begin
`ifdef MULTICYCLE_ALU_MULDIV_EN
          hi  <= hi_n;
          lo  <= lo_n;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(DW-1)) begin
            state     <= DONE;
            cnt       <= '0;
            OutDest   <= md_res;
            OutFlags  <= md_flg;
            DivByZero <= dz;
          end
`else
          state <= IDLE;
`endif
        end
        DONE: if (OutReady) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: random + directed checks of multicycle_alu (DATA_WIDTH=8)
// against a plain-arithmetic reference model.
module tb_multicycle_alu;
  localparam int DW = 8;
`ifdef MULTICYCLE_ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic          Clock = 1'b0;
  logic          Reset, InValid, InReady;
  logic          OutValid, OutReady, DivByZero;
  logic [3:0]    Operation, InFlags, OutFlags;
  logic [DW-1:0] InSrc, InDest, OutDest;
  int total = 0;
  int bad = 0;

  always #5 Clock = ~Clock;

  multicycle_alu #(.DATA_WIDTH(DW), .OP_WIDTH(4)) dut (
    .Clock(Clock), .Reset(Reset),
    .InValid(InValid), .InReady(InReady),
    .Operation(Operation), .InSrc(InSrc),
    .InDest(InDest), .InFlags(InFlags),
    .OutValid(OutValid), .OutReady(OutReady),
    .OutDest(OutDest), .OutFlags(OutFlags),
    .DivByZero(DivByZero)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0] res;
    logic [3:0]    flg;
    logic          dz;
    int            lat;
  } exp_t;

  function automatic exp_t model(input logic [3:0] op,
                                 input logic [DW-1:0] s,
                                 input logic [DW-1:0] d,
                                 input logic [3:0] f);
    exp_t e;
    int sd, ss, u, w;
    longint p;
    logic [DW:0] t;
    logic c, v;
    bit def;
    int maxv, minv;
    maxv = (1 << (DW-1)) - 1;
    minv = -(1 << (DW-1));
    sd = $signed(d);
    ss = $signed(s);
    e.res = '0; e.flg = f; e.dz = 1'b0; e.lat = 1;
    c = f[3]; v = f[0]; def = 1'b1; p = 0;
    case (op)
      4'd0: e.res = s;
      4'd1: e.res = ~(d & s);
      4'd2: e.res = ~(d | s);
      4'd3: begin t = {s, f[3]}; e.res = t[DW-1:0]; c = t[DW]; end
      4'd4: begin t = {f[3], s}; e.res = t[DW:1]; c = t[0]; end
      4'd5: begin
        u = int'(d) + int'(s) + int'(f[3]);
        w = sd + ss + int'(f[3]);
        e.res = DW'(u);
        c = u > ((1 << DW) - 1);
        v = (w > maxv) || (w < minv);
      end
      4'd6: begin
        u = int'(d) - int'(s) - int'(f[3]);
        w = sd - ss - int'(f[3]);
        e.res = DW'(u);
        c = u < 0;
        v = (w > maxv) || (w < minv);
      end
      4'd7, 4'd8: begin
        def = MD;
        p = longint'(sd) * longint'(ss);
        e.res = (op == 4'd7) ? DW'(p) : DW'(p >>> DW);
        if (op == 4'd7) v = (p > maxv) || (p < minv);
      end
      4'd9, 4'd10: begin
        def = MD;
        if (ss == 0) begin
          e.dz = MD;
          e.res = (op == 4'd9) ? '1 : d;
        end else if (op == 4'd9 && sd == minv && ss == -1) begin
          e.res = DW'(minv);
          v = 1'b1;
        end else begin
          e.res = (op == 4'd9) ? DW'(sd / ss) : DW'(sd % ss);
        end
      end
      default: def = 1'b0;
    endcase
    if (MD && op >= 4'd7 && op <= 4'd10) e.lat = DW + 1;
    if (def) e.flg = {c, e.res == '0, e.res[DW-1], v};
    else begin e.res = '0; e.flg = f; e.dz = 1'b0; end
    return e;
  endfunction

  task automatic scramble();
    Operation = 4'($urandom);
    InSrc     = DW'($urandom);
    InDest    = DW'($urandom);
    InFlags   = 4'($urandom);
  endtask

  task automatic run_op(input logic [3:0] op,
                        input logic [DW-1:0] s,
                        input logic [DW-1:0] d,
                        input logic [3:0] f,
                        input int hold,
                        input string tag);
    exp_t e;
    int lat;
    e = model(op, s, d, f);
    lat = 0;
    while (!InReady && lat < 50) begin
      @(posedge Clock); #1; lat++;
    end
    chk({tag, "/rdy"}, 64'(InReady), 64'(1));
    Operation = op; InSrc = s; InDest = d; InFlags = f;
    InValid = 1'b1; OutReady = 1'b0;
    @(posedge Clock); #1;
    InValid = 1'b0;
    scramble();
    lat = 1;
    while (!OutValid && lat < 40) begin
      InValid = 1'($urandom);
      @(posedge Clock); #1;
      scramble();
      lat++;
    end
    chk({tag, "/lat"}, 64'(lat), 64'(e.lat));
    chk({tag, "/res"}, 64'(OutDest), 64'(e.res));
    chk({tag, "/flg"}, 64'(OutFlags), 64'(e.flg));
    chk({tag, "/dz"}, 64'(DivByZero), 64'(e.dz));
    for (int i = 0; i < hold; i++) begin
      InValid = 1'b1;
      scramble();
      @(posedge Clock); #1;
      chk({tag, "/hold_v"}, 64'({OutValid, InReady}), 64'(2'b10));
      chk({tag, "/hold_d"}, 64'({OutDest, OutFlags, DivByZero}),
          64'({e.res, e.flg, e.dz}));
    end
    InValid = 1'b0;
    OutReady = 1'b1;
    @(posedge Clock); #1;
    OutReady = 1'b0;
    chk({tag, "/ack"}, 64'({OutValid, InReady}), 64'(2'b01));
  endtask

  logic [DW-1:0] pool [5];

  function automatic logic [DW-1:0] pick();
    if ($urandom_range(0, 2) == 0) return pool[$urandom_range(0, 4)];
    return DW'($urandom);
  endfunction

  initial begin
    int seen;
    pool = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
    Reset = 1'b1; InValid = 1'b0; OutReady = 1'b0;
    Operation = '0; InSrc = '0; InDest = '0; InFlags = '0;
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_hs", 64'({InReady, OutValid}), 64'(2'b10));
    chk("rst_out", 64'({OutDest, OutFlags, DivByZero}), 64'(0));
    Reset = 1'b0;

    run_op(4'd5, 8'h01, 8'h7F, 4'b0000, 0, "adc_ovf");
    run_op(4'd7, 8'd5, 8'hFD, 4'b0000, 0, "mul");
    run_op(4'd8, 8'd5, 8'hFD, 4'b1001, 0, "muh");
    run_op(4'd9, 8'd2, 8'hF9, 4'b0000, 0, "div");
    run_op(4'd10, 8'd2, 8'hF9, 4'b0000, 0, "mod");
    run_op(4'd9, 8'd0, 8'h35, 4'b0000, 0, "div0");
    run_op(4'd10, 8'd0, 8'hC5, 4'b0000, 0, "mod0");
    run_op(4'd9, 8'hFF, 8'h80, 4'b0000, 0, "div_ovf");
    run_op(4'd6, 8'h01, 8'h80, 4'b1000, 0, "sub_ovf");
    run_op(4'd3, 8'h81, 8'h00, 4'b1000, 5, "hold5");
    run_op(4'd15, 8'h12, 8'h34, 4'b1010, 1, "undef");

    // reset in the 4th BUSY cycle of a DIV discards it
    Operation = 4'd9; InSrc = 8'd2; InDest = 8'hF9; InFlags = '0;
    InValid = 1'b1;
    @(posedge Clock); #1;
    InValid = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    chk("rst_busy", 64'({InReady, OutValid}), 64'(2'b10));
    seen = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge Clock); #1;
      if (OutValid) seen++;
    end
    chk("rst_nopulse", 64'(seen), 64'(0));
    run_op(4'd3, 8'hA5, 8'h00, 4'b1000, 0, "rol_after");

    // reset wins over a simultaneous acceptance
    Operation = 4'd5; InSrc = 8'd1; InDest = 8'd1; InValid = 1'b1;
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0; InValid = 1'b0;
    chk("rst_acc", 64'({InReady, OutValid}), 64'(2'b10));

    for (int n = 0; n < 200; n++) begin
      run_op(4'($urandom_range(0, 15)), pick(), pick(),
             4'($urandom), $urandom_range(0, 2), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
